gps_l1ca_signal_gen: RTL and testbench
======================================

# gps_l1ca_signal_gen

- Synthetic GPS L1 C/A IF signal generator for the receiver's loopback bench and on-chip self-test.
- Produces a sampled IF stream for one SV: C/A code (G1/G2 Gold code) XOR navigation data, BPSK-modulated onto a carrier NCO, with programmable code rate, carrier rate and initial code phase.
- Output matches the front-end sample format (1-bit sign, 1-bit magnitude), one sample per enable strobe at SAMPLE_RATE.
- Sits in place of the RF front end, feeding the acquisition and tracking channels.

## Interface

Parameters:
- NCO_W, 32, width of the code and carrier phase accumulators and FCW inputs

Ports:
- clk  in  1  system clock; one clock, reset is asynchronous and active-high
- rst  in  1  asynchronous active-high reset
- en  in  1  sample strobe; one output sample per cycle with en=1
- start  in  1  pulse: latch sv, init_chip, fcws; begin slew
- sv  in  sv_t  PRN index minus 1 (0..31 → PRN 1..32)
- init_chip  in  gps_chip_t  starting chip index, 0..1022
- code_fcw  in  NCO_W  code NCO increment (nominal 228841226 = 1.023 MHz)
- carr_fcw  in  NCO_W  carrier NCO increment (nominal 899258778 = IF_RATE)
- nav_valid  in  1  nav_bit is valid
- nav_bit  in  1  next navigation data bit
- nav_ready  out  1  one-cycle pulse: nav_bit consumed at a bit edge
- busy  out  1  high during SLEW
- running  out  1  high in RUN
- sample_valid  out  1  sample strobe
- sample_sign  out  1  sample sign bit
- sample_mag  out  1  sample magnitude bit
- chip  out  gps_chip_t  current chip index
- epoch  out  1  one-cycle pulse on code wrap (1 ms)
- bit_edge  out  1  one-cycle pulse on data bit boundary (every 20 epochs)
- nav_underrun  out  1  sticky: bit edge occurred with nav_valid=0

## Operation

- States: IDLE, SLEW, RUN.
- IDLE → SLEW on start, from any state.
- start loads:
  - G1 and G2 to all ones, chip=0, ms counter=0, both NCO phases=0.
  - Latches sv, init_chip, code_fcw, carr_fcw.
  - Clears nav_underrun; current nav bit=0.
- SLEW:
  - Advances G1/G2 and chip by one per clk, ignoring en, until chip == init_chip.
  - Then → RUN. init_chip=0 goes straight to RUN on the next cycle.
- RUN, per en cycle:
  - code phase += code_fcw; carry-out advances the chip.
  - carrier phase += carr_fcw, modulo 2^NCO_W.
- Chip advance:
  - G1 feedback taps 3,10; G2 taps 2,3,6,8,9,10.
  - Code bit = G1[10] XOR (G2[a] XOR G2[b]), with (a,b) the per-SV phase selector pair (PRN1 = 2,6).
- Chip 1022 → 0:
  - Reload G1/G2 to all ones and pulse epoch.
  - Increment ms counter 0..19.
- ms 19 → 0:
  - Pulse bit_edge.
  - If nav_valid, take nav_bit and pulse nav_ready.
  - Else keep the previous bit and set nav_underrun.
- Sample:
  - sign = code_bit XOR nav bit XOR carr_phase[NCO_W-1].
  - mag = carr_phase[NCO_W-2] XOR carr_phase[NCO_W-3].
- In IDLE/SLEW: sample_valid=0, epoch/bit_edge/nav_ready=0.

## Timing

- Reset values:
  - Outputs: all 0, chip=0.
  - State: IDLE, LFSRs all ones.
- Latency: sample_valid, sample_sign and sample_mag are registered, asserted the cycle after the en that produced them.
- chip, epoch and bit_edge update in the same registered cycle as the sample that uses the new chip.
- Sample formation:
  - The sample uses the code bit and nav bit after any advance in that en cycle.
  - It uses the carrier phase after the add.
- SLEW duration is exactly init_chip cycles; busy is high for those cycles only.
- Simultaneous events:
  - start during RUN or SLEW wins over en and restarts.
  - Epoch and bit edge on the same chip wrap pulse together.
- Wrap-around:
  - The code NCO can carry at most once per en; code_fcw ≥ 2^NCO_W is not supported.
  - Carrier wraps silently.
- Mid-operation reset returns everything to reset values immediately.

## Structure

- Shared package: add NCO_W default, nominal CODE_FCW and CARR_FCW constants, and an `l1ca_g2_taps(sv_t)` function returning the phase-selector pair.
- Package reuse: `l1ca_lfsr_t` for G1/G2, `gps_chip_t` for chip.
- Sub-module: `l1ca_code_gen`, holding G1/G2, chip counter, advance/reload and the code bit. It is shared with the receiver's replica generator.

## Test plan

- PRN1, init_chip=0, code_fcw=2^30:
  - Chips change every 4 en cycles.
  - First 10 code bits 1100100000 (octal 1440).
- PRN1, init_chip=0, code_fcw=2^30, continuous en:
  - epoch every 4092 en cycles.
  - bit_edge every 81840.
  - 1023 chips per epoch with 512 ones.
- init_chip=500:
  - busy high exactly 500 cycles.
  - First RUN chip=500.
  - Bits equal the PRN1 sequence from index 500.
- carr_fcw=2^30, code bit 0, nav 0: sign/mag sequence per en is (0,1),(1,0),(1,1),(0,0), repeating.
- nav_valid=0 at the first bit edge: nav_underrun=1, nav_ready never pulses, sign sequence unchanged.
- nav_valid=1, nav_bit=1 at the first bit edge: nav_ready pulses once, and all subsequent signs invert relative to the nav=0 run.
- start asserted mid-RUN: next cycle state SLEW/RUN, chip reset, epoch timing restarts from 0.

Source files
------------

// File: rtl/gps_l1ca_signal_gen_pkg.sv
// Shared types and constants for the GPS L1 C/A synthetic signal generator
// and the receiver-side replica code generator.
package gps_l1ca_signal_gen_pkg;

  localparam int NCO_W_DEF = 32;
  localparam logic [31:0] CODE_FCW_NOM = 32'd228841226;
  localparam logic [31:0] CARR_FCW_NOM = 32'd899258778;

  typedef logic [4:0]  sv_t;
  typedef logic [9:0]  gps_chip_t;
  typedef logic [10:1] l1ca_lfsr_t;
  typedef logic [3:0]  g2_tap_t;

  typedef struct packed {
    g2_tap_t a;
    g2_tap_t b;
  } l1ca_taps_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SLEW,
    ST_RUN
  } gen_state_t;

  localparam gps_chip_t  LAST_CHIP = 10'd1022;
  localparam logic [4:0] LAST_MS   = 5'd19;

  // G2 phase-selector pair for PRN (sv + 1)
  function automatic l1ca_taps_t l1ca_g2_taps(input sv_t sv);
    l1ca_taps_t t;
    case (sv)
      5'd0:  t = {4'd2, 4'd6};
      5'd1:  t = {4'd3, 4'd7};
      5'd2:  t = {4'd4, 4'd8};
      5'd3:  t = {4'd5, 4'd9};
      5'd4:  t = {4'd1, 4'd9};
      5'd5:  t = {4'd2, 4'd10};
      5'd6:  t = {4'd1, 4'd8};
      5'd7:  t = {4'd2, 4'd9};
      5'd8:  t = {4'd3, 4'd10};
      5'd9:  t = {4'd2, 4'd3};
      5'd10: t = {4'd3, 4'd4};
      5'd11: t = {4'd5, 4'd6};
      5'd12: t = {4'd6, 4'd7};
      5'd13: t = {4'd7, 4'd8};
      5'd14: t = {4'd8, 4'd9};
      5'd15: t = {4'd9, 4'd10};
      5'd16: t = {4'd1, 4'd4};
      5'd17: t = {4'd2, 4'd5};
      5'd18: t = {4'd3, 4'd6};
      5'd19: t = {4'd4, 4'd7};
      5'd20: t = {4'd5, 4'd8};
      5'd21: t = {4'd6, 4'd9};
      5'd22: t = {4'd1, 4'd3};
      5'd23: t = {4'd4, 4'd6};
      5'd24: t = {4'd5, 4'd7};
      5'd25: t = {4'd6, 4'd8};
      5'd26: t = {4'd7, 4'd9};
      5'd27: t = {4'd8, 4'd10};
      5'd28: t = {4'd1, 4'd6};
      5'd29: t = {4'd2, 4'd7};
      5'd30: t = {4'd3, 4'd8};
      default: t = {4'd4, 4'd9};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/gps_l1ca_signal_gen_code_gen.sv
// C/A Gold code generator: G1/G2 registers, chip counter and the code bit that
// results from this cycle's load/advance. Shared with the receiver replica.
module l1ca_code_gen
  import gps_l1ca_signal_gen_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  sv_t       sv,
  input  logic      load,
  input  logic      adv,
  output gps_chip_t chip,
  output logic      at_last,
  output logic      code_bit_nxt
);

  l1ca_lfsr_t g1_q, g1_d, g2_q, g2_d;
  gps_chip_t  chip_q, chip_d;
  l1ca_taps_t taps;

  assign taps = l1ca_g2_taps(sv);

  function automatic logic code_of(input l1ca_lfsr_t g1, input l1ca_lfsr_t g2,
                                   input l1ca_taps_t t);
    return g1[10] ^ g2[t.a] ^ g2[t.b];
  endfunction

  always_comb begin
    g1_d   = g1_q;
    g2_d   = g2_q;
    chip_d = chip_q;
    if (load) begin
      g1_d   = '1;
      g2_d   = '1;
      chip_d = '0;
    end else if (adv) begin
      // Reload at the code wrap rather than relying on the 1023-step period
      if (chip_q == LAST_CHIP) begin
        g1_d   = '1;
        g2_d   = '1;
        chip_d = '0;
      end else begin
        g1_d   = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
        g2_d   = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
        chip_d = chip_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g1_q   <= '1;
      g2_q   <= '1;
      chip_q <= '0;
    end else begin
      g1_q   <= g1_d;
      g2_q   <= g2_d;
      chip_q <= chip_d;
    end
  end

  assign chip         = chip_q;
  assign at_last      = (chip_q == LAST_CHIP);
  assign code_bit_nxt = code_of(g1_d, g2_d, taps);

endmodule

// File: rtl/gps_l1ca_signal_gen.sv
// Synthetic GPS L1 C/A IF generator: slews the code to a start chip, then
// emits BPSK (code ^ nav) on a carrier NCO as 1-bit sign / 1-bit magnitude.
module gps_l1ca_signal_gen
  import gps_l1ca_signal_gen_pkg::*;
#(
  parameter int NCO_W = NCO_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  sv_t              sv,
  input  gps_chip_t        init_chip,
  input  logic [NCO_W-1:0] code_fcw,
  input  logic [NCO_W-1:0] carr_fcw,
  input  logic             nav_valid,
  input  logic             nav_bit,
  output logic             nav_ready,
  output logic             busy,
  output logic             running,
  output logic             sample_valid,
  output logic             sample_sign,
  output logic             sample_mag,
  output gps_chip_t        chip,
  output logic             epoch,
  output logic             bit_edge,
  output logic             nav_underrun
);

  gen_state_t       state_q, state_d;
  sv_t              sv_q, sv_d;
  gps_chip_t        init_q, init_d;
  logic [NCO_W-1:0] code_fcw_q, code_fcw_d, carr_fcw_q, carr_fcw_d;
  logic [NCO_W-1:0] code_ph_q, code_ph_d, carr_ph_q, carr_ph_d;
  logic [4:0]       ms_q, ms_d;
  logic             nav_q, nav_d, underrun_q, underrun_d;
  logic             valid_q, valid_d, sign_q, sign_d, mag_q, mag_d;
  logic             epoch_q, epoch_d, bit_edge_q, bit_edge_d, nav_ready_q, nav_ready_d;

  logic [NCO_W:0]   code_sum;
  logic             run_en, code_adv, wrap, at_last, code_bit_nxt;
  gps_chip_t        chip_cur;

  assign code_sum = {1'b0, code_ph_q} + {1'b0, code_fcw_q};
  assign run_en   = (state_q == ST_RUN) && en && !start;
  assign code_adv = ((state_q == ST_SLEW) && !start) || (run_en && code_sum[NCO_W]);
  assign wrap     = run_en && code_sum[NCO_W] && at_last;

  l1ca_code_gen u_code (
    .clk          (clk),
    .rst          (rst),
    .sv           (sv_q),
    .load         (start),
    .adv          (code_adv),
    .chip         (chip_cur),
    .at_last      (at_last),
    .code_bit_nxt (code_bit_nxt)
  );

  always_comb begin
    state_d     = state_q;
    sv_d        = sv_q;
    init_d      = init_q;
    code_fcw_d  = code_fcw_q;
    carr_fcw_d  = carr_fcw_q;
    code_ph_d   = code_ph_q;
    carr_ph_d   = carr_ph_q;
    ms_d        = ms_q;
    nav_d       = nav_q;
    underrun_d  = underrun_q;
    valid_d     = 1'b0;
    sign_d      = sign_q;
    mag_d       = mag_q;
    epoch_d     = 1'b0;
    bit_edge_d  = 1'b0;
    nav_ready_d = 1'b0;
    if (start) begin
      state_d    = (init_chip == '0) ? ST_RUN : ST_SLEW;
      sv_d       = sv;
      init_d     = init_chip;
      code_fcw_d = code_fcw;
      carr_fcw_d = carr_fcw;
      code_ph_d  = '0;
      carr_ph_d  = '0;
      ms_d       = '0;
      nav_d      = 1'b0;
      underrun_d = 1'b0;
    end else begin
      case (state_q)
        ST_SLEW: begin
          if (chip_cur + 10'd1 == init_q) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (en) begin
            code_ph_d = code_sum[NCO_W-1:0];
            carr_ph_d = carr_ph_q + carr_fcw_q;
            valid_d   = 1'b1;
            if (wrap) begin
              epoch_d = 1'b1;
              if (ms_q == LAST_MS) begin
                ms_d       = '0;
                bit_edge_d = 1'b1;
                if (nav_valid) begin
                  nav_d       = nav_bit;
                  nav_ready_d = 1'b1;
                end else begin
                  underrun_d = 1'b1;
                end
              end else begin
                ms_d = ms_q + 5'd1;
              end
            end
            // Sample reflects the post-advance code/nav bit and post-add carrier
            sign_d = code_bit_nxt ^ nav_d ^ carr_ph_d[NCO_W-1];
            mag_d  = carr_ph_d[NCO_W-2] ^ carr_ph_d[NCO_W-3];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sv_q        <= '0;
      init_q      <= '0;
      code_fcw_q  <= '0;
      carr_fcw_q  <= '0;
      code_ph_q   <= '0;
      carr_ph_q   <= '0;
      ms_q        <= '0;
      nav_q       <= 1'b0;
      underrun_q  <= 1'b0;
      valid_q     <= 1'b0;
      sign_q      <= 1'b0;
      mag_q       <= 1'b0;
      epoch_q     <= 1'b0;
      bit_edge_q  <= 1'b0;
      nav_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sv_q        <= sv_d;
      init_q      <= init_d;
      code_fcw_q  <= code_fcw_d;
      carr_fcw_q  <= carr_fcw_d;
      code_ph_q   <= code_ph_d;
      carr_ph_q   <= carr_ph_d;
      ms_q        <= ms_d;
      nav_q       <= nav_d;
      underrun_q  <= underrun_d;
      valid_q     <= valid_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      epoch_q     <= epoch_d;
      bit_edge_q  <= bit_edge_d;
      nav_ready_q <= nav_ready_d;
    end
  end

  assign busy         = (state_q == ST_SLEW);
  assign running      = (state_q == ST_RUN);
  assign sample_valid = valid_q;
  assign sample_sign  = sign_q;
  assign sample_mag   = mag_q;
  assign chip         = chip_cur;
  assign epoch        = epoch_q;
  assign bit_edge     = bit_edge_q;
  assign nav_ready    = nav_ready_q;
  assign nav_underrun = underrun_q;

endmodule

// File: tb/tb_gps_l1ca_signal_gen.sv
// Bench for gps_l1ca_signal_gen: C/A codes built from G1 and delayed G2
// sequences, with an arithmetic NCO/epoch/nav model of the sample stream.
module tb_gps_l1ca_signal_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, start = 1'b0, nav_valid = 1'b0, nav_bit = 1'b0;
  logic [4:0]  sv = '0;
  logic [9:0]  init_chip = '0;
  logic [31:0] code_fcw = '0, carr_fcw = '0;
  logic        nav_ready, busy, running, sample_valid, sample_sign, sample_mag;
  logic [9:0]  chip;
  logic        epoch, bit_edge, nav_underrun;

  int errors = 0;
  int checks = 0;

  gps_l1ca_signal_gen #(.NCO_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .sv(sv), .init_chip(init_chip),
    .code_fcw(code_fcw), .carr_fcw(carr_fcw), .nav_valid(nav_valid), .nav_bit(nav_bit),
    .nav_ready(nav_ready), .busy(busy), .running(running), .sample_valid(sample_valid),
    .sample_sign(sample_sign), .sample_mag(sample_mag), .chip(chip), .epoch(epoch),
    .bit_edge(bit_edge), .nav_underrun(nav_underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // C/A code as G1(n) ^ G2(n - delay), delays per PRN 1..32
  int g2_delay[32] = '{5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256, 257, 258,
                       469, 470, 471, 472, 473, 474, 509, 512, 513, 514, 515, 516, 859, 860, 861, 862};
  bit g1s[1023];
  bit g2s[1023];
  bit ca[1023];

  int          m_chip, m_ms;
  logic [31:0] m_code_ph, m_code_fcw, m_carr, m_carr_fcw;
  logic        m_nav, m_underrun;
  logic        e_valid, e_sign, e_mag, e_epoch, e_bit_edge, e_nav_ready;

  bit          sign_ref[20501];
  int          nav_prn;
  logic [31:0] nav_cf;

  task automatic build_seqs();
    for (int n = 0; n < 10; n++) begin
      g1s[n] = 1'b1;
      g2s[n] = 1'b1;
    end
    for (int n = 10; n < 1023; n++) begin
      g1s[n] = g1s[n-3] ^ g1s[n-10];
      g2s[n] = g2s[n-2] ^ g2s[n-3] ^ g2s[n-6] ^ g2s[n-8] ^ g2s[n-9] ^ g2s[n-10];
    end
  endtask

  task automatic model_idle();
    e_valid = 1'b0; e_epoch = 1'b0; e_bit_edge = 1'b0; e_nav_ready = 1'b0;
  endtask

  task automatic model_start(input int prn0, input int init, input logic [31:0] kf,
                             input logic [31:0] cf);
    int d;
    d = g2_delay[prn0];
    for (int n = 0; n < 1023; n++) ca[n] = g1s[n] ^ g2s[(n + 1023 - d) % 1023];
    m_chip = init; m_ms = 0; m_nav = 1'b0; m_underrun = 1'b0;
    m_code_ph = '0; m_carr = '0; m_code_fcw = kf; m_carr_fcw = cf;
    e_sign = 1'b0; e_mag = 1'b0;
    model_idle();
  endtask

  task automatic model_step(input logic nv, input logic nb);
    logic [32:0] s;
    model_idle();
    e_valid = 1'b1;
    s = {1'b0, m_code_ph} + {1'b0, m_code_fcw};
    m_code_ph = s[31:0];
    if (s[32]) begin
      if (m_chip == 1022) begin
        m_chip = 0;
        e_epoch = 1'b1;
        if (m_ms == 19) begin
          m_ms = 0;
          e_bit_edge = 1'b1;
          if (nv) begin
            m_nav = nb;
            e_nav_ready = 1'b1;
          end else begin
            m_underrun = 1'b1;
          end
        end else begin
          m_ms++;
        end
      end else begin
        m_chip++;
      end
    end
    m_carr = m_carr + m_carr_fcw;
    e_sign = ca[m_chip] ^ m_nav ^ m_carr[31];
    e_mag  = m_carr[30] ^ m_carr[29];
  endtask

  function automatic logic [15:0] exp_vec();
    logic [9:0] c;
    c = m_chip[9:0];
    return {e_valid, e_sign & e_valid, e_mag & e_valid, c, e_epoch, e_bit_edge, e_nav_ready};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {sample_valid, sample_sign & sample_valid, sample_mag & sample_valid, chip,
            epoch, bit_edge, nav_ready};
  endfunction

  task automatic tick(input logic e, input logic nv, input logic nb);
    @(negedge clk);
    start = 1'b0; en = e; nav_valid = nv; nav_bit = nb;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int prn0, input int init, input logic [31:0] kf,
                          input logic [31:0] cf, input logic e);
    @(negedge clk);
    start = 1'b1; sv = prn0[4:0]; init_chip = init[9:0]; code_fcw = kf; carr_fcw = cf; en = e;
    @(posedge clk);
    #1;
    model_start(prn0, init, kf, cf);
  endtask

  task automatic wait_run(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1100) begin
      tick(1'b0, 1'b0, 1'b0);
      cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, running, sample_valid, sample_sign, sample_mag, epoch, bit_edge, nav_ready,
         nav_underrun} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {busy, running, sample_valid, sample_sign,
               sample_mag, epoch, bit_edge, nav_ready, nav_underrun});
    end
    checks++;
    if (chip !== 10'd0) begin
      errors++;
      $display("FAIL reset_chip got=%0d exp=0", chip);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      checks++;
      if ({running, busy, sample_valid} !== 3'b000) begin
        errors++;
        $display("FAIL idle_no_sample got=%b exp=000", {running, busy, sample_valid});
      end
    end
  endtask

  task automatic test_prn1_code();
    logic [9:0] cw;
    int last, nbits;
    cw = '0; last = -1; nbits = 0;
    do_start(0, 0, 32'h4000_0000, 32'h0, 1'b0);
    checks++;
    if ({running, busy} !== 2'b10) begin
      errors++;
      $display("FAIL start_to_run got=%b exp=10", {running, busy});
    end
    for (int i = 1; i <= 44; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      model_step(1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL prn1_sample en=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (int'(chip) != last && nbits < 10) begin
        cw[9-nbits] = sample_sign;
        nbits++;
        last = int'(chip);
      end
    end
    checks++;
    if (cw !== 10'o1440) begin
      errors++;
      $display("FAIL prn1_first10 got=%o exp=1440", cw);
    end
  endtask

  task automatic test_epoch();
    int ones, distinct, last, ep1, ep2;
    ones = 0; distinct = 0; last = -1; ep1 = -1; ep2 = -1;
    do_start(0, 0, 32'h4000_0000, 32'h0, 1'b0);
    for (int i = 1; i <= 8200; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      model_step(1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL epoch_sample en=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (epoch === 1'b1) begin
        if (ep1 < 0) ep1 = i;
        else if (ep2 < 0) ep2 = i;
      end
      if (int'(chip) != last && distinct < 1023) begin
        ones += int'(sample_sign);
        distinct++;
        last = int'(chip);
      end
    end
    checks++;
    if (ep1 != 4092) begin
      errors++;
      $display("FAIL epoch_first got=%0d exp=4092", ep1);
    end
    checks++;
    if (ep2 - ep1 != 4092) begin
      errors++;
      $display("FAIL epoch_period got=%0d exp=4092", ep2 - ep1);
    end
    checks++;
    if (distinct != 1023 || ones != 512) begin
      errors++;
      $display("FAIL epoch_chip_count got=%0d chips %0d ones exp=1023 chips 512 ones",
               distinct, ones);
    end
  endtask

  task automatic test_nav_underrun();
    int edge_at, ready_cnt;
    logic nb;
    edge_at = -1; ready_cnt = 0;
    do_start(nav_prn, 0, 32'hFFFF_FFFF, nav_cf, 1'b0);
    for (int i = 1; i <= 20500; i++) begin
      nb = 1'($urandom);
      tick(1'b1, 1'b0, nb);
      model_step(1'b0, nb);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL underrun_sample en=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      sign_ref[i] = sample_sign;
      if (bit_edge === 1'b1 && edge_at < 0) edge_at = i;
      if (nav_ready === 1'b1) ready_cnt++;
      if (i == 20460) begin
        checks++;
        if (nav_underrun !== 1'b0) begin
          errors++;
          $display("FAIL underrun_early got=%b exp=0", nav_underrun);
        end
      end
    end
    checks++;
    if (edge_at != 20461) begin
      errors++;
      $display("FAIL underrun_bit_edge_at got=%0d exp=20461", edge_at);
    end
    checks++;
    if (nav_underrun !== 1'b1 || ready_cnt != 0) begin
      errors++;
      $display("FAIL underrun_flag got=%b ready=%0d exp=1 ready=0", nav_underrun, ready_cnt);
    end
  endtask

  task automatic test_nav_take();
    int ready_cnt, diffs;
    logic inv;
    ready_cnt = 0; diffs = 0;
    do_start(nav_prn, 0, 32'hFFFF_FFFF, nav_cf, 1'b0);
    for (int i = 1; i <= 20500; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      model_step(1'b1, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL navtake_sample en=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      inv = (i >= 20461);
      if (sample_sign !== (sign_ref[i] ^ inv)) diffs++;
      if (nav_ready === 1'b1) ready_cnt++;
    end
    checks++;
    if (ready_cnt != 1 || nav_underrun !== 1'b0) begin
      errors++;
      $display("FAIL navtake_ready got=%0d underrun=%b exp=1 underrun=0", ready_cnt, nav_underrun);
    end
    checks++;
    if (diffs != 0) begin
      errors++;
      $display("FAIL navtake_inversion got=%0d differing signs exp=0", diffs);
    end
  endtask

  task automatic test_slew();
    int cnt;
    cnt = 0;
    do_start(0, 500, 32'h4000_0000, 32'h0, 1'b0);
    while (busy === 1'b1 && cnt < 2000) begin
      cnt++;
      tick(1'($urandom), 1'b0, 1'b0);
      checks++;
      if (sample_valid !== 1'b0) begin
        errors++;
        $display("FAIL slew_no_sample cyc=%0d got=%b exp=0", cnt, sample_valid);
      end
    end
    checks++;
    if (cnt != 500) begin
      errors++;
      $display("FAIL slew_busy_cycles got=%0d exp=500", cnt);
    end
    checks++;
    if ({running, chip} !== {1'b1, 10'd500}) begin
      errors++;
      $display("FAIL slew_first_chip got=%b/%0d exp=1/500", running, chip);
    end
    for (int i = 1; i <= 40; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      model_step(1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL slew_seq en=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_carrier();
    logic [1:0] pat[4];
    int cnt;
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b11; pat[3] = 2'b00;
    do_start(0, 5, 32'h0, 32'h4000_0000, 1'b0);
    wait_run(cnt);
    checks++;
    if (cnt != 5 || running !== 1'b1) begin
      errors++;
      $display("FAIL carrier_slew got=%0d running=%b exp=5 running=1", cnt, running);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      model_step(1'b0, 1'b0);
      checks++;
      if ({sample_sign, sample_mag} !== pat[i%4] || chip !== 10'd5) begin
        errors++;
        $display("FAIL carrier_pattern en=%0d got=%b chip=%0d exp=%b chip=5", i,
                 {sample_sign, sample_mag}, chip, pat[i%4]);
      end
    end
  endtask

  task automatic test_restart();
    int ep, cnt;
    ep = -1;
    do_start($urandom_range(0, 31), 0, 32'h8000_0000, $urandom, 1'b0);
    for (int i = 1; i <= 100; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      model_step(1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL restart_pre en=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    do_start($urandom_range(0, 31), 0, 32'h8000_0000, $urandom, 1'b1);
    checks++;
    if ({running, busy, sample_valid, chip} !== {3'b100, 10'd0}) begin
      errors++;
      $display("FAIL restart_state got=%b exp=1000000000000", {running, busy, sample_valid, chip});
    end
    for (int i = 1; i <= 2100; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      model_step(1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL restart_run en=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (epoch === 1'b1 && ep < 0) ep = i;
    end
    checks++;
    if (ep != 2046) begin
      errors++;
      $display("FAIL restart_epoch got=%0d exp=2046", ep);
    end
    do_start(3, 7, 32'h8000_0000, 32'h0, 1'b1);
    checks++;
    if ({busy, running, chip} !== {2'b10, 10'd0}) begin
      errors++;
      $display("FAIL restart_to_slew got=%b exp=100000000000", {busy, running, chip});
    end
    wait_run(cnt);
    checks++;
    if (cnt != 7 || chip !== 10'd7) begin
      errors++;
      $display("FAIL restart_slew_len got=%0d chip=%0d exp=7 chip=7", cnt, chip);
    end
  endtask

  task automatic test_random();
    int prn, init, cnt;
    logic e, nv, nb;
    for (int r = 0; r < 6; r++) begin
      prn  = $urandom_range(0, 31);
      init = (r % 2 == 1) ? $urandom_range(1000, 1022) : $urandom_range(0, 60);
      do_start(prn, init, $urandom, $urandom, 1'b0);
      wait_run(cnt);
      checks++;
      if (cnt != init || running !== 1'b1 || int'(chip) != init) begin
        errors++;
        $display("FAIL random_slew run=%0d got=%0d chip=%0d exp=%0d", r, cnt, chip, init);
      end
      for (int i = 1; i <= 300; i++) begin
        e  = ($urandom_range(0, 3) != 0);
        nv = 1'($urandom);
        nb = 1'($urandom);
        tick(e, nv, nb);
        if (e) model_step(nv, nb);
        else model_idle();
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL random_sample run=%0d cyc=%0d got=%h exp=%h", r, i, obs_vec(), exp_vec());
        end
      end
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, running, sample_valid, sample_sign, sample_mag, epoch, bit_edge, nav_ready,
         nav_underrun, chip} !== 19'b0) begin
      errors++;
      $display("FAIL midrst_outputs got=%b exp=0", {busy, running, sample_valid, sample_sign,
               sample_mag, epoch, bit_edge, nav_ready, nav_underrun, chip});
    end
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if ({running, sample_valid} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_idle got=%b exp=00", {running, sample_valid});
    end
  endtask

  initial begin
    build_seqs();
    nav_prn = $urandom_range(0, 31);
    nav_cf  = $urandom;
    test_reset();
    test_prn1_code();
    test_epoch();
    test_slew();
    test_carrier();
    test_nav_underrun();
    test_nav_take();
    test_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
